// File: rtl/cce_pkg.sv
// Shared definitions for the colour-conversion engine: mode codes, luma weights, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cce_pkg;

    // Conversion mode encoding; any value not listed here converts as gray.
    localparam logic [1:0] CCE_MODE_GRAY   = 2'd0;
    localparam logic [1:0] CCE_MODE_INV    = 2'd1;
    localparam logic [1:0] CCE_MODE_THRESH = 2'd2;

    // BT.601-style integer luma weights. They sum to 256, so a right shift by 8
    // normalises the result and the output can never exceed full scale.
    localparam int CCE_COEF_R     = 77;
    localparam int CCE_COEF_G     = 150;
    localparam int CCE_COEF_B     = 29;
    localparam int CCE_LUMA_SHIFT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } cce_state_e;

endpackage

// File: rtl/cce_if.sv
// Source/sink frame-memory port bundle between the engine and its two BRAMs.
// Latency: source returns rd_data one cycle after rd_en and holds it while rd_en is low.
// Backpressure: sink completes a write only when wr_en && wr_ready.
interface cce_mem_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
) ();
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [3*PIX_W-1:0]  rd_data;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIX_W-1:0]    wr_data;
    logic                wr_ready;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, wr_ready
    );
endinterface

// File: rtl/cce_luma.sv
// Registered luma stage: luma = (77R + 150G + 29B) >> 8 on a {R,G,B} word.
// Latency: 1 cycle while en_i is high.
// Backpressure: en_i low freezes both the result and its valid flag.
module cce_luma
    import cce_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               vld_i,
    input  logic [3*PIX_W-1:0] rgb_i,
    output logic               vld_o,
    output logic [PIX_W-1:0]   luma_o
);
    // Two spare bits above the exact PIX_W+8 product width keep the sum safe
    // if the weights are ever retuned.
    localparam int SW = PIX_W + 10;
    localparam logic [SW-1:0] KR = SW'(CCE_COEF_R);
    localparam logic [SW-1:0] KG = SW'(CCE_COEF_G);
    localparam logic [SW-1:0] KB = SW'(CCE_COEF_B);

    logic [SW-1:0]    r_ext, g_ext, b_ext;
    logic [SW-1:0]    sum;
    logic [PIX_W-1:0] luma_d;
    logic [PIX_W-1:0] luma_q;
    logic             vld_q;

    assign r_ext  = SW'(rgb_i[3*PIX_W-1 -: PIX_W]);
    assign g_ext  = SW'(rgb_i[2*PIX_W-1 -: PIX_W]);
    assign b_ext  = SW'(rgb_i[PIX_W-1   -: PIX_W]);
    assign sum    = r_ext * KR + g_ext * KG + b_ext * KB;
    assign luma_d = PIX_W'(sum >> CCE_LUMA_SHIFT);

    // Advance the weighted sum only when the pipeline is not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            luma_q <= '0;
        end else if (en_i) begin
            vld_q  <= vld_i;
            luma_q <= luma_d;
        end
    end

    assign vld_o  = vld_q;
    assign luma_o = luma_q;
endmodule

// File: rtl/color_convert_engine.sv
// Frame-level RGB to single-channel converter (gray / inverted / threshold under CCE_THRESH_EN).
// Latency: rd_en to wr_en is 3 cycles plus stall cycles; 1 pixel/clock when unstalled.
// Backpressure: wr_en && !wr_ready freezes every stage, the read address and the read strobe.
module color_convert_engine
    import cce_pkg::*;
#(
    parameter int IMG_WIDTH  = 220,
    parameter int IMG_HEIGHT = 220,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] thresh,
    output logic             busy,
    output logic             done,
    cce_mem_if.master        mem
);
    localparam int                N         = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    cce_state_e        state_q;
    logic              busy_q, done_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        mode_q;

    // S1 tracks the address of the word the source is presenting this cycle;
    // the source register itself holds the pixel, so no data copy is kept here.
    logic              s1_vld_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s2_vld;
    logic [PIX_W-1:0]  s2_luma;
    logic [ADDR_W-1:0] s2_addr_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic [PIX_W-1:0]  wr_data_d;

    logic              stall;
    logic              advance;
    logic              rd_fire;

`ifdef CCE_THRESH_EN
    logic [PIX_W-1:0]  thresh_q;
`else
    logic              unused_thresh;
    assign unused_thresh = ^thresh;
`endif

    assign stall   = wr_en_q && !mem.wr_ready;
    assign advance = !stall;
    assign rd_fire = (state_q == ST_RUN) && advance;

    // Frame sequencing: latch configuration, walk the source addresses, wait for drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            mode_q    <= CCE_MODE_GRAY;
`ifdef CCE_THRESH_EN
            thresh_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
`ifdef CCE_THRESH_EN
                        thresh_q  <= thresh;
`endif
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        if (rd_addr_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!s1_vld_q && !s2_vld && (!wr_en_q || mem.wr_ready)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pair each issued read with its address so it meets the data one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s2_addr_q <= '0;
        end else if (advance) begin
            s1_vld_q  <= rd_fire;
            s1_addr_q <= rd_addr_q;
            s2_addr_q <= s1_addr_q;
        end
    end

    cce_luma #(
        .PIX_W (PIX_W)
    ) u_luma (
        .clk    (clk),
        .rst    (rst),
        .en_i   (advance),
        .vld_i  (s1_vld_q),
        .rgb_i  (mem.rd_data),
        .vld_o  (s2_vld),
        .luma_o (s2_luma)
    );

    // Mode selection on the luma value; all-ones minus x is simply ~x.
    always_comb begin
        wr_data_d = s2_luma;
        case (mode_q)
            CCE_MODE_INV: wr_data_d = ~s2_luma;
`ifdef CCE_THRESH_EN
            CCE_MODE_THRESH: wr_data_d = (s2_luma >= thresh_q) ? '1 : '0;
`endif
            default: wr_data_d = s2_luma;
        endcase
    end

    // Output stage; data and address only change when a new pixel lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (advance) begin
            wr_en_q <= s2_vld;
            if (s2_vld) begin
                wr_addr_q <= s2_addr_q;
                wr_data_q <= wr_data_d;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem.rd_en   = rd_fire;
    assign mem.rd_addr = rd_addr_q;
    assign mem.wr_en   = wr_en_q;
    assign mem.wr_addr = wr_addr_q;
    assign mem.wr_data = wr_data_q;
endmodule
